pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised elastic pipeline register, the successor to the fixed stall/bubble stage registers between pipeline stages. It carries one control bundle and one data bundle per beat under a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`, so there is no combinational path from `out_ready` back to `in_ready`. A synchronous flush kills all in-flight beats, so a control hazard becomes a bubble without a separate bubble input.

## Interface
- `DATA_W`, 32: width of data bundle (ALU result, PC+imm, store data, etc., concatenated by the instantiator).
- `CTRL_W`, 5: width of control bundle (Branch, MemRead, MemtoReg, MemWrite, RegWrite, ...). Zeroed whenever the beat is invalid.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held beats.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  DATA_W  upstream data bundle.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream accepts beat this cycle.
- `out_ctrl`  out  CTRL_W  control bundle; all-zero when `out_valid`=0.
- `out_data`  out  DATA_W  data bundle; don't-care when `out_valid`=0.
- `occupancy`  out  2  beats held: 0, 1 or 2.

## Operation
- Storage: main register (drives outputs) and skid register; each has ctrl, data and valid fields.
- State encoding: EMPTY (0 beats), ONE (main valid), TWO (main and skid valid). `occupancy` equals the state count.
- `in_ready` = (state != TWO). It is a registered decode and never depends on `out_ready` or `in_valid`.
- Accept: `in_valid` & `in_ready`. Drain: `out_valid` & `out_ready`.
- EMPTY: on accept, load main and go to ONE. Otherwise stay.
- ONE:
  - accept & drain: load main from input, stay ONE.
  - accept & !drain: load skid from input, go to TWO.
  - !accept & drain: go to EMPTY.
  - neither: hold.
- TWO:
  - drain: main <= skid, go to ONE. Input is not accepted because `in_ready`=0.
  - !drain: hold everything.
- Ordering: beats leave strictly in arrival order. No beat is dropped or duplicated except by flush.
- flush:
  - Next state is EMPTY.
  - main and skid ctrl fields and valid bits are cleared; data fields may keep stale values.
  - A beat offered in the flush cycle is discarded, even if `in_ready`=1.
  - A drain in the same cycle still completes, because downstream samples before the edge.
- `out_ctrl` is driven from the main ctrl register. That register is written as zero on every transition to EMPTY, so there is no output gating logic.
- Reset (`rst`=0, asynchronous): state EMPTY; all ctrl, data and valid registers 0. Outputs: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `in_ready`=1. Assertion mid-transfer loses all held beats immediately.
- Reset release: first accept is possible on the first rising edge after `rst` goes high.

## Timing
- Latency: a beat accepted at edge N appears on the outputs after edge N (visible in cycle N+1).
- Throughput: one beat per cycle sustained while `out_ready`=1.
- Back-pressure: after `out_ready` drops, at most one further beat is absorbed (into skid). `in_ready` falls on the following edge.
- Recovery: one cycle after `out_ready` reasserts, `in_ready` rises again.
- Priority: `rst` > `flush` > handshake.
- Handshake rules: `in_ctrl`/`in_data` are sampled only on accept edges. `out_*` are stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset: hold `rst`=0 with `in_valid`=1 and `in_data`=32'hDEAD_BEEF. Required: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1, `occupancy`=0. Release, then one edge. Required: `out_data`=32'hDEAD_BEEF, `occupancy`=1.
- Streaming: send beats 1..8, ctrl=5'b10101, with `out_ready`=1 throughout. Required: outputs 1..8 on consecutive cycles one cycle behind the input, `in_ready` constantly 1, `occupancy` constantly 1 after the first beat.
- Back-pressure: stream 1..6 and drop `out_ready` for 3 cycles after beat 2 is presented. Required: beat 3 is skidded, `occupancy`=2, `in_ready`=0 for exactly those cycles. Output order 1..6 with no loss or duplication.
- Flush while full: flush in TWO while offering beat 9. Required: next cycle `occupancy`=0, `out_valid`=0, `out_ctrl`=0, beat 9 never appears. Beat 10 offered afterwards appears next.
- Asynchronous reset mid-stream: pulse `rst` low between edges while in TWO. Required: outputs clear immediately without waiting for a clock edge.
- Random: random `in_valid`/`out_ready`/`flush` for 10k cycles against a scoreboard queue. Required: no ordering error, and `out_ctrl`=0 whenever `out_valid`=0.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one elastic pipeline stage: upstream beat in, downstream beat out.
// A beat moves on an edge where valid and ready are both high; valid never waits on ready.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a two-entry skid buffer and synchronous flush.
// in_ready decodes only the state register, so out_ready never reaches it combinationally.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_skid_if.slave     bus,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_main_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_accept;
  logic w_drain;
  logic w_main_ld_in;
  logic w_main_ld_skid;
  logic w_main_clr;
  logic w_skid_ld;
  logic w_skid_clr;

  assign bus.in_ready  = (r_state != TWO);
  assign bus.out_valid = r_main_valid;
  assign bus.out_ctrl  = r_main_ctrl;
  assign bus.out_data  = r_main_data;
  assign occupancy     = r_state;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_drain  = r_main_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_main_clr     = 1'b0;
    w_skid_ld      = 1'b0;
    w_skid_clr     = 1'b0;
    if (flush) begin
      // A drain in this cycle already completed downstream; everything else dies.
      w_state_nxt = EMPTY;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ONE;
            w_main_ld_in = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_main_ld_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = TWO;
            w_skid_ld   = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = EMPTY;
            w_main_clr  = 1'b1;
          end
        end
        TWO: begin
          if (w_drain) begin
            w_state_nxt    = ONE;
            w_main_ld_skid = 1'b1;
            w_skid_clr     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_clr  = 1'b1;
          w_skid_clr  = 1'b1;
        end
      endcase
    end
  end

  // Main ctrl is zeroed whenever the stage empties, so out_ctrl needs no gating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
    end else if (w_main_clr) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
    end else if (w_main_ld_in) begin
      r_main_valid <= 1'b1;
      r_main_ctrl  <= bus.in_ctrl;
      r_main_data  <= bus.in_data;
    end else if (w_main_ld_skid) begin
      r_main_valid <= r_skid_valid;
      r_main_ctrl  <= r_skid_ctrl;
      r_main_data  <= r_skid_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (w_skid_clr) begin
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
    end else if (w_skid_ld) begin
      r_skid_valid <= 1'b1;
      r_skid_ctrl  <= bus.in_ctrl;
      r_skid_data  <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random stimulus for pipe_stage_skid, checked every cycle against a FIFO model.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 5;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stage is a FIFO of at most two beats.
  logic [DATA_W-1:0] exp_q[$];
  logic [CTRL_W-1:0] ctrl_q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = exp_q.size();
    chk("occupancy", 64'(occupancy), 64'(sz));
    chk("in_ready",  64'(bus.in_ready), 64'(sz < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(sz > 0));
    chk("out_ctrl",  64'(bus.out_ctrl), (sz > 0) ? 64'(ctrl_q[0]) : 64'd0);
    if (sz > 0) chk("out_data", 64'(bus.out_data), 64'(exp_q[0]));
  endtask

  // Check at the falling edge, then advance the model by the coming rising edge.
  task automatic do_cycle();
    bit drn;
    @(negedge clk);
    check_model();
    last_acc = bus.in_valid && (exp_q.size() < 2) && !flush;
    drn      = (exp_q.size() > 0) && bus.out_ready;
    if (drn) begin
      void'(exp_q.pop_front());
      void'(ctrl_q.pop_front());
    end
    if (flush) begin
      exp_q.delete();
      ctrl_q.delete();
    end else if (last_acc) begin
      exp_q.push_back(bus.in_data);
      ctrl_q.push_back(bus.in_ctrl);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  initial begin
    int idx;
    rst = 1'b0;
    drive(1'b1, 5'h1f, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Reset held with a beat offered: nothing may be captured.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_ctrl",  64'(bus.out_ctrl), 64'd0);
    chk("rst_out_data",  64'(bus.out_data), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);

    rst = 1'b1;
    do_cycle();
    drive(1'b0, 5'h0, 32'h0, 1'b0, 1'b0);
    do_cycle();
    chk("post_rst_data", 64'(bus.out_data), 64'hDEAD_BEEF);
    chk("post_rst_occ",  64'(occupancy), 64'd1);
    drive(1'b0, 5'h0, 32'h0, 1'b1, 1'b0);
    do_cycle();

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'b10101, 32'(i), 1'b1, 1'b0);
      do_cycle();
    end
    drive(1'b0, 5'h0, 32'h0, 1'b1, 1'b0);
    do_cycle();
    do_cycle();

    // Back-pressure: out_ready low for three cycles after beat 2 is presented.
    idx = 1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      drive(idx <= 6, 5'b00111, 32'(idx), !(cyc >= 2 && cyc < 5), 1'b0);
      do_cycle();
      if (last_acc) idx++;
    end
    chk("bp_all_sent", 64'(idx), 64'd7);
    drive(1'b0, 5'h0, 32'h0, 1'b1, 1'b0);
    do_cycle();

    // Fill to two beats, then flush while offering beat 9.
    drive(1'b1, 5'b11000, 32'd7, 1'b0, 1'b0);
    do_cycle();
    drive(1'b1, 5'b11000, 32'd8, 1'b0, 1'b0);
    do_cycle();
    chk("full_occ", 64'(occupancy), 64'd2);
    drive(1'b1, 5'b11111, 32'd9, 1'b0, 1'b1);
    do_cycle();
    chk("flush_occ",   64'(occupancy), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_ctrl",  64'(bus.out_ctrl), 64'd0);
    drive(1'b1, 5'b00001, 32'd10, 1'b1, 1'b0);
    do_cycle();
    chk("after_flush_data", 64'(bus.out_data), 64'd10);
    drive(1'b0, 5'h0, 32'h0, 1'b1, 1'b0);
    do_cycle();

    // Asynchronous reset between edges while holding two beats.
    drive(1'b1, 5'b01010, 32'd11, 1'b0, 1'b0);
    do_cycle();
    drive(1'b1, 5'b01010, 32'd12, 1'b0, 1'b0);
    do_cycle();
    chk("pre_arst_occ", 64'(occupancy), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_ctrl",  64'(bus.out_ctrl), 64'd0);
    chk("arst_out_data",  64'(bus.out_data), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_in_ready",  64'(bus.in_ready), 64'd1);
    exp_q.delete();
    ctrl_q.delete();
    drive(1'b0, 5'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    do_cycle();

    // Random traffic against the model.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive($urandom_range(0, 99) < 70, CTRL_W'($urandom), $urandom,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4);
      do_cycle();
    end

    drive(1'b0, 5'h0, 32'h0, 1'b1, 1'b0);
    do_cycle();
    do_cycle();
    do_cycle();
    chk("final_empty", 64'(occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
